// File: rtl/nrf_pkg.sv
// nRF24L01 command bytes, STATUS flag masks and TX sequencer types shared by
// the RX and TX controllers.
package nrf_pkg;

  localparam logic [7:0] W_REGISTER   = 8'h20;
  localparam logic [7:0] STATUS_REG   = 8'h07;
  localparam logic [7:0] W_TX_PAYLOAD = 8'hA0;
  localparam logic [7:0] FLUSH_TX     = 8'hE1;
  localparam logic [7:0] NOP          = 8'hFF;

  localparam logic [7:0] RX_DR  = 8'h40;
  localparam logic [7:0] TX_DS  = 8'h20;
  localparam logic [7:0] MAX_RT = 8'h10;

  // Writing 1s to all three interrupt flags clears them in one STATUS write.
  localparam logic [7:0] CLEAR_IRQ_FLAGS = RX_DR | TX_DS | MAX_RT;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_WTX_CMD,
    ST_PAYLOAD,
    ST_CSN_GAP,
    ST_CE_PULSE,
    ST_WAIT_IRQ,
    ST_RD_STATUS,
    ST_CLR_FLAGS,
    ST_CLR_GAP,
    ST_FLUSH,
    ST_DONE
  } tx_state_t;

  typedef enum logic [1:0] {
    RESULT_TX_DS   = 2'b00,
    RESULT_MAX_RT  = 2'b01,
    RESULT_TIMEOUT = 2'b10
  } tx_result_t;

  // TX_DS takes priority over MAX_RT; neither flag means the IRQ was spurious.
  function automatic tx_result_t decode_tx_result(input logic [7:0] status);
    if ((status & TX_DS) != 8'h00) begin
      return RESULT_TX_DS;
    end else if ((status & MAX_RT) != 8'h00) begin
      return RESULT_MAX_RT;
    end else begin
      return RESULT_TIMEOUT;
    end
  endfunction

endpackage

// File: rtl/nrf_delay_counter.sv
// Loadable down-counter that stops at zero; done is high while the count is zero.
module nrf_delay_counter #(
  parameter int WIDTH = 15
) (
  input  logic             i_Clk,
  input  logic             i_Rst,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic             decrement,
  output logic             done
);

  logic [WIDTH-1:0] count;

  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      count <= '0;
    end else if (load) begin
      count <= load_value;
    end else if (decrement && (count != '0)) begin
      count <= count - 1'b1;
    end
  end

  assign done = (count == '0);

endmodule

// File: rtl/nrf_tx_controller.sv
// PTX sequencer for the nRF24L01: loads a payload, pulses CE, waits for IRQ,
// reads/clears STATUS, flushes the TX FIFO on failure and reports the result.
module nrf_tx_controller
  import nrf_pkg::*;
#(
  parameter int PAYLOAD_BYTES   = 4,
  parameter int CE_PULSE_CYCLES = 250,
  parameter int TIMEOUT_CYCLES  = 25000
) (
  input  logic                       i_Clk,
  input  logic                       i_Rst,
  input  logic                       i_Start,
  input  logic [8*PAYLOAD_BYTES-1:0] i_Payload,
  input  logic                       i_TX_Ready,
  input  logic                       i_RX_DV,
  input  logic [7:0]                 i_RX_Byte,
  input  logic                       i_IRQ_n,
  output logic [7:0]                 o_Data,
  output logic                       o_TX_DV,
  output logic                       o_SPI_Csn,
  output logic                       o_CE,
  output logic                       o_Busy,
  output logic                       o_Done,
  output logic [1:0]                 o_Result,
  output logic [7:0]                 o_Status_Reg
);

  localparam int CNT_MAX  = (CE_PULSE_CYCLES > TIMEOUT_CYCLES) ? CE_PULSE_CYCLES : TIMEOUT_CYCLES;
  localparam int CNT_W    = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam int IDX_W    = (PAYLOAD_BYTES > 1) ? $clog2(PAYLOAD_BYTES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(PAYLOAD_BYTES - 1);
  localparam logic [CNT_W-1:0] CE_LOAD  = CNT_W'(CE_PULSE_CYCLES - 1);
  localparam logic [CNT_W-1:0] TO_LOAD  = CNT_W'(TIMEOUT_CYCLES - 1);

  tx_state_t                  state, state_n;
  logic [IDX_W-1:0]           byte_idx, byte_idx_n;
  logic                       sent, sent_n;
  logic [8*PAYLOAD_BYTES-1:0] payload_q, payload_n;
  logic [7:0]                 status_q, status_n;
  tx_result_t                 result_q, result_n;

  logic             spi_active;
  logic             byte_done;
  logic             cnt_load;
  logic [CNT_W-1:0] cnt_load_value;
  logic             cnt_dec;
  logic             cnt_done;

  nrf_delay_counter #(
    .WIDTH(CNT_W)
  ) u_delay (
    .i_Clk     (i_Clk),
    .i_Rst     (i_Rst),
    .load      (cnt_load),
    .load_value(cnt_load_value),
    .decrement (cnt_dec),
    .done      (cnt_done)
  );

  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      state     <= ST_IDLE;
      byte_idx  <= '0;
      sent      <= 1'b0;
      payload_q <= '0;
      status_q  <= 8'h00;
      result_q  <= RESULT_TX_DS;
    end else begin
      state     <= state_n;
      byte_idx  <= byte_idx_n;
      sent      <= sent_n;
      payload_q <= payload_n;
      status_q  <= status_n;
      result_q  <= result_n;
    end
  end

  assign spi_active = (state == ST_WTX_CMD) || (state == ST_PAYLOAD) ||
                      (state == ST_RD_STATUS) || (state == ST_CLR_FLAGS) ||
                      (state == ST_FLUSH);

  // 'sent' marks a byte handed to the SPI master and not yet acknowledged.
  assign byte_done = spi_active && sent && i_RX_DV;

  always_comb begin
    state_n        = state;
    byte_idx_n     = byte_idx;
    sent_n         = sent;
    payload_n      = payload_q;
    status_n       = status_q;
    result_n       = result_q;
    cnt_load       = 1'b0;
    cnt_load_value = '0;
    cnt_dec        = 1'b0;
    o_TX_DV        = 1'b0;

    if (spi_active) begin
      if (!sent && i_TX_Ready) begin
        o_TX_DV = 1'b1;
        sent_n  = 1'b1;
      end else if (byte_done) begin
        sent_n = 1'b0;
      end
    end

    case (state)
      ST_IDLE: begin
        if (i_Start) begin
          payload_n  = i_Payload;
          result_n   = RESULT_TX_DS;
          byte_idx_n = '0;
          sent_n     = 1'b0;
          state_n    = ST_WTX_CMD;
        end
      end
      ST_WTX_CMD: begin
        if (byte_done) begin
          byte_idx_n = '0;
          state_n    = ST_PAYLOAD;
        end
      end
      ST_PAYLOAD: begin
        if (byte_done) begin
          if (byte_idx == LAST_IDX) begin
            state_n = ST_CSN_GAP;
          end else begin
            byte_idx_n = byte_idx + 1'b1;
          end
        end
      end
      ST_CSN_GAP: begin
        cnt_load       = 1'b1;
        cnt_load_value = CE_LOAD;
        state_n        = ST_CE_PULSE;
      end
      ST_CE_PULSE: begin
        if (cnt_done) begin
          cnt_load       = 1'b1;
          cnt_load_value = TO_LOAD;
          state_n        = ST_WAIT_IRQ;
        end else begin
          cnt_dec = 1'b1;
        end
      end
      ST_WAIT_IRQ: begin
        // IRQ is checked first so it wins a tie with the timeout.
        if (!i_IRQ_n) begin
          state_n = ST_RD_STATUS;
        end else if (cnt_done) begin
          result_n = RESULT_TIMEOUT;
          state_n  = ST_RD_STATUS;
        end else begin
          cnt_dec = 1'b1;
        end
      end
      ST_RD_STATUS: begin
        if (byte_done) begin
          status_n = i_RX_Byte;
          state_n  = ST_CLR_FLAGS;
        end
      end
      ST_CLR_FLAGS: begin
        if (byte_done) begin
          if (result_q != RESULT_TIMEOUT) begin
            result_n = decode_tx_result(status_q);
          end
          state_n = ST_CLR_GAP;
        end
      end
      ST_CLR_GAP: begin
        state_n = (result_q == RESULT_TX_DS) ? ST_DONE : ST_FLUSH;
      end
      ST_FLUSH: begin
        if (byte_done) begin
          state_n = ST_DONE;
        end
      end
      ST_DONE: begin
        state_n = ST_IDLE;
      end
      default: begin
        state_n = ST_IDLE;
      end
    endcase
  end

  always_comb begin
    o_Data = 8'h00;
    case (state)
      ST_WTX_CMD:   o_Data = W_TX_PAYLOAD;
      ST_PAYLOAD:   o_Data = payload_q[{byte_idx, 3'b000} +: 8];
      ST_RD_STATUS: o_Data = W_REGISTER | STATUS_REG;
      ST_CLR_FLAGS: o_Data = CLEAR_IRQ_FLAGS;
      ST_FLUSH:     o_Data = FLUSH_TX;
      default:      o_Data = 8'h00;
    endcase
  end

  assign o_SPI_Csn    = !spi_active;
  assign o_CE         = (state == ST_CE_PULSE);
  assign o_Busy       = (state != ST_IDLE) && (state != ST_DONE);
  assign o_Done       = (state == ST_DONE);
  assign o_Result     = result_q;
  assign o_Status_Reg = status_q;

endmodule

// File: tb/tb_nrf_tx_controller.sv
// Self-checking bench for nrf_tx_controller: randomized SPI slave/radio model
// with a transaction-level reference of the expected MOSI frames and result.
module tb_nrf_tx_controller;

  localparam int PB     = 4;
  localparam int CE_CYC = 250;
  localparam int TO_CYC = 25000;

  logic            i_Clk;
  logic            i_Rst;
  logic            i_Start;
  logic [8*PB-1:0] i_Payload;
  logic            i_TX_Ready;
  logic            i_RX_DV;
  logic [7:0]      i_RX_Byte;
  logic            i_IRQ_n;
  logic [7:0]      o_Data;
  logic            o_TX_DV;
  logic            o_SPI_Csn;
  logic            o_CE;
  logic            o_Busy;
  logic            o_Done;
  logic [1:0]      o_Result;
  logic [7:0]      o_Status_Reg;

  nrf_tx_controller #(
    .PAYLOAD_BYTES  (PB),
    .CE_PULSE_CYCLES(CE_CYC),
    .TIMEOUT_CYCLES (TO_CYC)
  ) dut (
    .i_Clk       (i_Clk),
    .i_Rst       (i_Rst),
    .i_Start     (i_Start),
    .i_Payload   (i_Payload),
    .i_TX_Ready  (i_TX_Ready),
    .i_RX_DV     (i_RX_DV),
    .i_RX_Byte   (i_RX_Byte),
    .i_IRQ_n     (i_IRQ_n),
    .o_Data      (o_Data),
    .o_TX_DV     (o_TX_DV),
    .o_SPI_Csn   (o_SPI_Csn),
    .o_CE        (o_CE),
    .o_Busy      (o_Busy),
    .o_Done      (o_Done),
    .o_Result    (o_Result),
    .o_Status_Reg(o_Status_Reg)
  );

  initial i_Clk = 1'b0;
  always #5 i_Clk = ~i_Clk;

  int checks   = 0;
  int failures = 0;

  // Observed MOSI bytes in order; -1 marks each chip-select release.
  int         trace[$];
  int         ce_runs[$];
  int         wait_runs[$];
  int         done_count = 0;
  int         proto_err  = 0;
  logic [7:0] status_resp = 8'h0E;

  task automatic check_output(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // SPI master + radio model: drives inputs on negedge, samples 1 time unit before posedge.
  bit         pending  = 1'b0;
  int         lat      = 0;
  logic [7:0] held     = 8'h00;
  logic [7:0] cur_resp = 8'h00;
  logic       prev_csn = 1'b1;
  int         ce_len   = 0;
  int         wait_len = 0;
  bit         in_wait  = 1'b0;

  always begin
    @(negedge i_Clk);
    i_RX_DV = 1'b0;
    if (pending) begin
      if (lat == 0) begin
        i_RX_DV   = 1'b1;
        i_RX_Byte = cur_resp;
        pending   = 1'b0;
      end else begin
        lat--;
      end
    end
    i_TX_Ready = !pending && ($urandom_range(0, 3) != 0);
    #4;
    if (o_TX_DV === 1'b1) begin
      if (i_TX_Ready !== 1'b1 || pending) proto_err++;
      trace.push_back(int'(o_Data));
      held     = o_Data;
      pending  = 1'b1;
      lat      = $urandom_range(0, 3);
      cur_resp = (o_Data == 8'h27) ? status_resp : 8'h0E;
    end else if (pending && (o_Data !== held)) begin
      proto_err++;
    end
    if (o_SPI_Csn === 1'b1 && prev_csn === 1'b0) trace.push_back(-1);
    prev_csn = o_SPI_Csn;
    if (o_CE === 1'b1) begin
      ce_len++;
      if (o_SPI_Csn !== 1'b1) proto_err++;
      in_wait = 1'b0;
    end else if (ce_len > 0) begin
      ce_runs.push_back(ce_len);
      ce_len   = 0;
      in_wait  = 1'b1;
      wait_len = 0;
    end
    if (in_wait) begin
      if (o_SPI_Csn === 1'b1 && o_Busy === 1'b1) begin
        wait_len++;
      end else begin
        wait_runs.push_back(wait_len);
        in_wait = 1'b0;
      end
    end
    if (o_Done === 1'b1) done_count++;
  end

  // irq_delay: -1 never, 0 during the CE pulse, d>0 asserted in the d-th wait cycle.
  task automatic apply_stimulus(input logic [8*PB-1:0] payload, input logic [7:0] status,
                                input int irq_delay, input bit start_in_wait,
                                input bit start_in_done, input string name);
    int         n;
    int         k;
    int         d0;
    bit         timed_out;
    int         exp_wait;
    logic [1:0] exp_res;
    int         exp_trace[$];

    trace.delete();
    ce_runs.delete();
    wait_runs.delete();
    d0          = done_count;
    status_resp = status;

    i_Payload = payload;
    i_Start   = 1'b1;
    @(negedge i_Clk);
    i_Start   = 1'b0;
    i_Payload = $urandom;

    n = 0;
    while (o_CE !== 1'b1 && n < 1000) begin @(negedge i_Clk); n++; end
    if (o_CE !== 1'b1) begin check_output({name, "_ce_rise"}, 0, 1); return; end
    if (irq_delay == 0) begin
      repeat (10) @(negedge i_Clk);
      i_IRQ_n = 1'b0;
    end
    n = 0;
    while (o_CE === 1'b1 && n < CE_CYC + 20) begin @(negedge i_Clk); n++; end
    if (o_CE === 1'b1) begin check_output({name, "_ce_fall"}, 0, 1); return; end

    k = 1;
    if (start_in_wait) begin
      i_Payload = ~payload;
      i_Start   = 1'b1;
      @(negedge i_Clk);
      i_Start   = 1'b0;
      k         = 2;
    end
    if (irq_delay > 0) begin
      repeat (irq_delay - k) @(negedge i_Clk);
      i_IRQ_n = 1'b0;
    end

    n = 0;
    while (o_Done !== 1'b1 && n < TO_CYC + 2000) begin @(negedge i_Clk); n++; end
    if (o_Done !== 1'b1) begin check_output({name, "_done_wait"}, 0, 1); return; end
    if (start_in_done) i_Start = 1'b1;
    @(negedge i_Clk);
    i_Start = 1'b0;
    i_IRQ_n = 1'b1;
    repeat (4) @(negedge i_Clk);

    timed_out = (irq_delay < 0) || (irq_delay > TO_CYC);
    exp_wait  = (irq_delay < 0) ? TO_CYC : (irq_delay == 0) ? 1 :
                (irq_delay > TO_CYC) ? TO_CYC : irq_delay;
    if (timed_out)                 exp_res = 2'b10;
    else if ((status & 8'h20) != 0) exp_res = 2'b00;
    else if ((status & 8'h10) != 0) exp_res = 2'b01;
    else                            exp_res = 2'b10;

    exp_trace.push_back(8'hA0);
    for (int i = 0; i < PB; i++) exp_trace.push_back(int'(payload[8*i +: 8]));
    exp_trace.push_back(-1);
    exp_trace.push_back(8'h27);
    exp_trace.push_back(8'h70);
    exp_trace.push_back(-1);
    if (exp_res != 2'b00) begin
      exp_trace.push_back(8'hE1);
      exp_trace.push_back(-1);
    end

    check_output({name, "_result"}, 32'(o_Result), 32'(exp_res));
    check_output({name, "_status_reg"}, 32'(o_Status_Reg), 32'(status));
    check_output({name, "_done_pulses"}, done_count - d0, 1);
    check_output({name, "_busy_after"}, 32'(o_Busy), 0);
    check_output({name, "_ce_len"}, (ce_runs.size() > 0) ? ce_runs[0] : -1, CE_CYC);
    check_output({name, "_ce_count"}, ce_runs.size(), 1);
    check_output({name, "_wait_len"}, (wait_runs.size() > 0) ? wait_runs[0] : -1, exp_wait);
    check_output({name, "_trace_len"}, trace.size(), exp_trace.size());
    for (int i = 0; i < exp_trace.size() && i < trace.size(); i++)
      check_output($sformatf("%s_trace%0d", name, i), trace[i], exp_trace[i]);
    check_output({name, "_protocol"}, proto_err, 0);
  endtask

  task automatic reset_mid_payload();
    int n;
    int d0;
    trace.delete();
    d0        = done_count;
    i_Payload = $urandom;
    i_Start   = 1'b1;
    @(negedge i_Clk);
    i_Start = 1'b0;
    n = 0;
    while (trace.size() < 2 && n < 500) begin @(negedge i_Clk); n++; end
    check_output("rst_reached_payload", 32'(trace.size() >= 2), 1);
    i_Rst = 1'b1;
    @(negedge i_Clk);
    check_output("rst_csn", 32'(o_SPI_Csn), 1);
    check_output("rst_ce", 32'(o_CE), 0);
    check_output("rst_busy", 32'(o_Busy), 0);
    check_output("rst_done", 32'(o_Done), 0);
    i_Rst = 1'b0;
    repeat (50) @(negedge i_Clk);
    check_output("rst_no_done", done_count - d0, 0);
    check_output("rst_idle_busy", 32'(o_Busy), 0);
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    logic [7:0] pick[5];
    i_Rst     = 1'b1;
    i_Start   = 1'b0;
    i_Payload = '0;
    i_IRQ_n   = 1'b1;
    repeat (3) @(negedge i_Clk);
    check_output("reset_csn", 32'(o_SPI_Csn), 1);
    check_output("reset_ce", 32'(o_CE), 0);
    check_output("reset_tx_dv", 32'(o_TX_DV), 0);
    check_output("reset_data", 32'(o_Data), 0);
    check_output("reset_busy", 32'(o_Busy), 0);
    check_output("reset_done", 32'(o_Done), 0);
    check_output("reset_result", 32'(o_Result), 0);
    check_output("reset_status", 32'(o_Status_Reg), 0);
    i_Rst = 1'b0;
    repeat (3) @(negedge i_Clk);

    apply_stimulus(32'h44332211, 8'h2E, 100, 1'b0, 1'b0, "success");
    apply_stimulus($urandom, 8'h1E, 100, 1'b0, 1'b0, "max_rt");
    apply_stimulus($urandom, 8'h2E, -1, 1'b0, 1'b0, "timeout");
    apply_stimulus($urandom, 8'h3E, 0, 1'b0, 1'b0, "irq_in_ce");
    apply_stimulus($urandom, 8'h1E, 150, 1'b1, 1'b0, "start_busy");
    apply_stimulus($urandom, 8'h2E, 5, 1'b0, 1'b1, "start_done");
    reset_mid_payload();
    apply_stimulus($urandom, 8'h2E, TO_CYC, 1'b0, 1'b0, "irq_tie");

    pick = '{8'h2E, 8'h1E, 8'h0E, 8'h3E, 8'h00};
    for (int t = 0; t < 5; t++) begin
      pick[4] = 8'($urandom);
      apply_stimulus($urandom, pick[$urandom_range(0, 4)], $urandom_range(1, 400),
                     1'b0, 1'b0, $sformatf("rand%0d", t));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/nrf_tx_controller.md
Name: nrf_tx_controller

Overview:
Transmit-side (PTX) sequencer for the nRF24L01 radio. It is the counterpart of the receive controller and drives the same byte-level SPI master.
- On a start pulse it loads a fixed-length payload with W_TX_PAYLOAD, then pulses CE.
- It waits for IRQ, reads and clears STATUS, and flushes the TX FIFO on failure.
- It reports the result to the application layer.

Parameters:
PAYLOAD_BYTES, 4, payload length in bytes (1..32)
CE_PULSE_CYCLES, 250, CE high time in i_Clk cycles (≥10 µs at 25 MHz)
TIMEOUT_CYCLES, 25000, maximum wait for IRQ after CE falls (1 ms at 25 MHz)

Ports:
i_Clk  in  1  clock
i_Rst  in  1  reset, synchronous, active-high
i_Start  in  1  one-cycle request; ignored while o_Busy=1
i_Payload  in  8*PAYLOAD_BYTES  payload, sampled at accepted i_Start; byte 0 = bits [7:0]
i_TX_Ready  in  1  SPI master idle, can accept a byte
i_RX_DV  in  1  one-cycle pulse: SPI byte exchange complete
i_RX_Byte  in  8  MISO byte, valid with i_RX_DV
i_IRQ_n  in  1  radio IRQ, active-low, already synchronised
o_Data  out  8  MOSI byte to SPI master
o_TX_DV  out  1  one-cycle pulse: o_Data valid
o_SPI_Csn  out  1  radio chip select, active-low
o_CE  out  1  radio chip enable
o_Busy  out  1  sequence in progress
o_Done  out  1  one-cycle completion pulse
o_Result  out  2  00=TX_DS, 01=MAX_RT, 10=timeout; valid from o_Done until next accepted start
o_Status_Reg  out  8  STATUS byte captured in the IRQ read

Behaviour:
- Reset values: o_SPI_Csn=1, o_CE=0, o_TX_DV=0, o_Data=0, o_Busy=0, o_Done=0, o_Result=00, o_Status_Reg=0, state IDLE, counters 0.
- Reset mid-operation returns to IDLE on the next edge: Csn high, CE low, no o_Done.
- Byte handshake:
  - o_TX_DV pulses for one cycle, only when i_TX_Ready=1; o_Data is held stable through the byte.
  - Exactly one o_TX_DV per byte. The next byte is not issued until i_RX_DV for the previous byte.
  - Csn stays low for all bytes of one SPI command.
- States and transitions:
  - IDLE: on i_Start, latch payload, set o_Busy=1, go to WTX_CMD.
  - WTX_CMD: Csn=0; send 0xA0; on i_RX_DV go to PAYLOAD.
  - PAYLOAD: send byte index 0..PAYLOAD_BYTES-1. After the i_RX_DV of the last byte go to CSN_GAP.
  - CSN_GAP: Csn=1 for exactly one cycle, then CE_PULSE.
  - CE_PULSE: CE=1 for exactly CE_PULSE_CYCLES cycles, then CE=0 and go to WAIT_IRQ.
  - WAIT_IRQ: counter cleared on entry.
    - i_IRQ_n=0 → RD_STATUS.
    - Counter reaches TIMEOUT_CYCLES → set result=10, go to RD_STATUS.
    - If both occur in the same cycle, IRQ wins.
  - RD_STATUS: Csn=0; send 0x27 (W_REGISTER|STATUS). On i_RX_DV capture i_RX_Byte into o_Status_Reg, then go to CLR_FLAGS.
  - CLR_FLAGS: send 0x70; on i_RX_DV set Csn=1 for one cycle.
    - Result (unless timeout already set): bit5 set → 00; else bit4 set → 01; neither → 10.
    - Result 00 → DONE. Result 01 or 10 → FLUSH.
  - FLUSH: Csn=0; send 0xE1 (FLUSH_TX); on i_RX_DV set Csn=1 and go to DONE.
  - DONE: o_Done=1 for one cycle, o_Busy=0, go to IDLE.
- Boundary conditions:
  - i_Start while busy: no effect.
  - i_Start in the DONE cycle: ignored.
  - i_IRQ_n low during CE_PULSE: not acted on until WAIT_IRQ.
  - i_TX_Ready low: FSM stalls indefinitely, no timeout on SPI.
  - Counters are sized by $clog2 of their parameter and saturate, never wrap.

Decomposition:
- Shared package nrf_pkg, for use by both the RX and TX controllers:
  - Commands: W_REGISTER 0x20, STATUS_REG 0x07, W_TX_PAYLOAD 0xA0, FLUSH_TX 0xE1, NOP 0xFF.
  - Flag masks: RX_DR 0x40, TX_DS 0x20, MAX_RT 0x10.
  - TX state enum and result codes.
- One sub-module: nrf_delay_counter, a loadable down-counter with a done flag. It is used for both CE_PULSE and WAIT_IRQ timeout.

Test Plan:
- Start with payload 0x44332211, SPI model returning 0x0E → MOSI sequence A0,11,22,33,44. Csn low across all five bytes, then high ≥1 cycle.
- CE pulse: after payload → CE high for exactly 250 cycles, and Csn high throughout.
- Success: IRQ_n falls at 100 cycles after CE falls, MISO returns 0x2E at the 0x27 byte → MOSI 27,70. o_Status_Reg=0x2E, o_Result=00, no E1 sent, one o_Done pulse.
- MAX_RT: MISO returns 0x1E → o_Result=01, then separate Csn frame containing E1, then o_Done.
- Timeout: IRQ_n held high → after 25000 cycles MOSI 27,70, then E1; o_Result=10.
- Reset and busy: i_Rst asserted mid-PAYLOAD → next cycle Csn=1, CE=0, o_Busy=0, no o_Done. i_Start pulsed during WAIT_IRQ → no second transfer.
